// File: rtl/toy_bpu_fetch_responder.sv
// toy_bpu_fetch_responder: tags pcgen fetches into slots, issues them to imem,
// returns out-of-order rsps to the ROB as acks.
// Ports: clk, rst_n (async, active-low); fetch_req_* in; mem_req_* out;
// mem_rsp_* in; icache_ack_* out; busy out.
// Option: TOY_FETCH_RESP_BYPASS_EN adds a same-cycle rsp->ack path
// when the ack FIFO is empty.
module toy_bpu_fetch_responder #(
  parameter int FETCH_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int ENTRY_ID_WIDTH   = 4,
  parameter int OUTSTANDING      = 4,
  parameter int RSP_FIFO_DEPTH   = 4,
  localparam int TAG_WIDTH       = $clog2(OUTSTANDING)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_req_vld,
  output logic                        fetch_req_rdy,
  input  logic [ADDR_WIDTH-1:0]       fetch_req_pc,
  input  logic [ENTRY_ID_WIDTH-1:0]   fetch_req_entry_id,
  output logic                        mem_req_vld,
  input  logic                        mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [TAG_WIDTH-1:0]        mem_req_tag,
  input  logic                        mem_rsp_vld,
  input  logic [TAG_WIDTH-1:0]        mem_rsp_tag,
  input  logic [FETCH_DATA_WIDTH-1:0] mem_rsp_data,
  output logic                        icache_ack_vld,
  input  logic                        icache_ack_rdy,
  output logic [FETCH_DATA_WIDTH-1:0] icache_ack_pld,
  output logic [ENTRY_ID_WIDTH-1:0]   icache_ack_entry_id,
  output logic                        busy
);

  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = $clog2(OUTSTANDING + RSP_FIFO_DEPTH + 1);

  logic [OUTSTANDING-1:0]      slot_vld;
  logic [ENTRY_ID_WIDTH-1:0]   slot_id [OUTSTANDING];

  logic [FETCH_DATA_WIDTH-1:0] fifo_pld [RSP_FIFO_DEPTH];
  logic [ENTRY_ID_WIDTH-1:0]   fifo_id  [RSP_FIFO_DEPTH];
  logic [PW:0]                 wr_ptr;
  logic [PW:0]                 rd_ptr;
  logic [PW:0]                 fifo_cnt;
  logic                        fifo_empty;
  logic                        fifo_full;

  logic                        free_any;
  logic [TAG_WIDTH-1:0]        alloc_tag;
  logic [CW-1:0]               credit_used;
  logic                        accept;
  logic                        rsp_hit;
  logic                        bypass;
  logic                        push;
  logic                        pop;

  // Extra wrap bit: equal pointers mean empty, differing only in
  // the wrap bit means full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fifo_cnt   = wr_ptr - rd_ptr;

  always_comb begin
    free_any  = 1'b0;
    alloc_tag = '0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (!slot_vld[i]) begin
        free_any  = 1'b1;
        alloc_tag = TAG_WIDTH'(i);
      end
    end
  end

  // Every live slot owns a future FIFO entry, so bounding slots plus
  // queued acks by the depth keeps mem_rsp from ever overflowing.
  always_comb begin
    credit_used = CW'(fifo_cnt);
    for (int i = 0; i < OUTSTANDING; i++) begin
      credit_used = credit_used + CW'(slot_vld[i]);
    end
  end

  assign fetch_req_rdy = free_any &&
                         (credit_used < CW'(RSP_FIFO_DEPTH)) &&
                         (!mem_req_vld || mem_req_rdy);
  assign accept  = fetch_req_vld && fetch_req_rdy;
  assign rsp_hit = mem_rsp_vld && slot_vld[mem_rsp_tag];

`ifdef TOY_FETCH_RESP_BYPASS_EN
  assign bypass = rsp_hit && fifo_empty && icache_ack_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_hit && !bypass;
  assign pop  = !fifo_empty && icache_ack_rdy;
  assign busy = (|slot_vld) || mem_req_vld || !fifo_empty;

  always_comb begin
    icache_ack_vld      = 1'b0;
    icache_ack_pld      = '0;
    icache_ack_entry_id = '0;
    unique case (1'b1)
      !fifo_empty: begin
        icache_ack_vld      = 1'b1;
        icache_ack_pld      = fifo_pld[rd_ptr[PW-1:0]];
        icache_ack_entry_id = fifo_id[rd_ptr[PW-1:0]];
      end
      bypass: begin
        icache_ack_vld      = 1'b1;
        icache_ack_pld      = mem_rsp_data;
        icache_ack_entry_id = slot_id[mem_rsp_tag];
      end
      default: ;
    endcase
  end

  // Accept and response never touch the same slot in one cycle:
  // allocation takes an idle slot, a hit needs a live one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        slot_id[i] <= '0;
      end
    end else begin
      if (rsp_hit) begin
        slot_vld[mem_rsp_tag] <= 1'b0;
      end
      if (accept) begin
        slot_vld[alloc_tag] <= 1'b1;
        slot_id[alloc_tag]  <= fetch_req_entry_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_vld  <= 1'b0;
      mem_req_addr <= '0;
      mem_req_tag  <= '0;
    end else if (accept) begin
      mem_req_vld  <= 1'b1;
      mem_req_addr <= fetch_req_pc;
      mem_req_tag  <= alloc_tag;
    end else if (mem_req_rdy) begin
      mem_req_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Ack storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pld[wr_ptr[PW-1:0]] <= mem_rsp_data;
      fifo_id[wr_ptr[PW-1:0]]  <= slot_id[mem_rsp_tag];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && mem_rsp_vld) begin
      assert (slot_vld[mem_rsp_tag])
        else $warning("mem_rsp tag %0d on idle slot dropped", mem_rsp_tag);
    end
    if (rst_n && push) begin
      assert (!fifo_full)
        else $warning("ack fifo push while full");
    end
  end
`endif

endmodule

// File: tb/tb_toy_bpu_fetch_responder.sv
// tb_toy_bpu_fetch_responder: directed vectors for the fetch responder.
// Drives at posedge+1, samples at posedge+4; default (non-bypass) build.
module tb_toy_bpu_fetch_responder;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req_vld;
  logic          fetch_req_rdy;
  logic [AW-1:0] fetch_req_pc;
  logic [IW-1:0] fetch_req_entry_id;
  logic          mem_req_vld;
  logic          mem_req_rdy;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_vld;
  logic [TW-1:0] mem_rsp_tag;
  logic [DW-1:0] mem_rsp_data;
  logic          icache_ack_vld;
  logic          icache_ack_rdy;
  logic [DW-1:0] icache_ack_pld;
  logic [IW-1:0] icache_ack_entry_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toy_bpu_fetch_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_req_vld       (fetch_req_vld),
    .fetch_req_rdy       (fetch_req_rdy),
    .fetch_req_pc        (fetch_req_pc),
    .fetch_req_entry_id  (fetch_req_entry_id),
    .mem_req_vld         (mem_req_vld),
    .mem_req_rdy         (mem_req_rdy),
    .mem_req_addr        (mem_req_addr),
    .mem_req_tag         (mem_req_tag),
    .mem_rsp_vld         (mem_rsp_vld),
    .mem_rsp_tag         (mem_rsp_tag),
    .mem_rsp_data        (mem_rsp_data),
    .icache_ack_vld      (icache_ack_vld),
    .icache_ack_rdy      (icache_ack_rdy),
    .icache_ack_pld      (icache_ack_pld),
    .icache_ack_entry_id (icache_ack_entry_id),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [127:0] dat(input int id, input int tag);
    return {96'h0, 16'hF00D, 8'(id), 8'(tag)};
  endfunction

  task automatic send(input logic [31:0] pc, input int id, input int tag);
    fetch_req_vld      = 1'b1;
    fetch_req_pc       = pc;
    fetch_req_entry_id = IW'(id);
    settle();
    check("req_rdy", fetch_req_rdy, 1);
    tick();
    fetch_req_vld = 1'b0;
    settle();
    check("mreq_vld", mem_req_vld, 1);
    check("mreq_addr", mem_req_addr, pc);
    check("mreq_tag", mem_req_tag, tag);
  endtask

  // One rsp per cycle with ack_rdy=1; each ack shows up the next cycle.
  task automatic rsps(input int n, input int tags[4], input int ids[4]);
    for (int k = 0; k <= n; k++) begin
      mem_rsp_vld = (k < n);
      if (k < n) begin
        mem_rsp_tag  = TW'(tags[k]);
        mem_rsp_data = dat(ids[k], tags[k]);
      end
      settle();
      if (k > 0) begin
        check("ack_vld", icache_ack_vld, 1);
        check("ack_id", icache_ack_entry_id, ids[k-1]);
        check("ack_pld", icache_ack_pld, dat(ids[k-1], tags[k-1]));
      end else begin
        check("ack_idle", icache_ack_vld, 0);
      end
      tick();
    end
    mem_rsp_vld = 1'b0;
  endtask

  initial begin
    fetch_req_vld      = 1'b0;
    fetch_req_pc       = '0;
    fetch_req_entry_id = '0;
    mem_req_rdy        = 1'b1;
    mem_rsp_vld        = 1'b0;
    mem_rsp_tag        = '0;
    mem_rsp_data       = '0;
    icache_ack_rdy     = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_mreq_vld", mem_req_vld, 0);
    check("rst_ack_vld", icache_ack_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_pld", icache_ack_pld, 0);
    rst_n = 1'b1;
    settle();
    check("rst_rdy", fetch_req_rdy, 1);

    // single request, ack one cycle after rsp
    send(32'h1000, 3, 0);
    check("t1_busy", busy, 1);
    tick();
    settle();
    check("t1_mreq_done", mem_req_vld, 0);
    repeat (3) tick();
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = 2'd0;
    mem_rsp_data = 128'hA5A5;
    settle();
    check("t1_ack_early", icache_ack_vld, 0);
    tick();
    mem_rsp_vld = 1'b0;
    settle();
    check("t1_ack_vld", icache_ack_vld, 1);
    check("t1_ack_id", icache_ack_entry_id, 3);
    check("t1_ack_pld", icache_ack_pld, 128'hA5A5);
    tick();
    settle();
    check("t1_ack_gone", icache_ack_vld, 0);
    check("t1_idle", busy, 0);

    // four requests, out-of-order responses
    for (int i = 0; i < 4; i++) begin
      send(32'h100 * (i + 1), i, i);
    end
    rsps(4, '{2, 0, 3, 1}, '{2, 0, 3, 1});
    settle();
    check("t2_ack_gone", icache_ack_vld, 0);
    check("t2_idle", busy, 0);

    // all slots busy: fifth request waits for a freed slot and credit
    for (int i = 0; i < 4; i++) begin
      send(32'h200 * (i + 1), i + 8, i);
    end
    fetch_req_vld      = 1'b1;
    fetch_req_pc       = 32'h5000;
    fetch_req_entry_id = 4'd12;
    settle();
    check("t3_full_rdy", fetch_req_rdy, 0);
    tick();
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = 2'd1;
    mem_rsp_data = dat(9, 1);
    settle();
    check("t3_rsp_cyc_rdy", fetch_req_rdy, 0);
    tick();
    mem_rsp_vld = 1'b0;
    settle();
    // freed slot plus queued ack still consume all credit
    check("t3_credit_rdy", fetch_req_rdy, 0);
    check("t3_ack_id", icache_ack_entry_id, 9);
    check("t3_ack_vld", icache_ack_vld, 1);
    tick();
    settle();
    check("t3_rdy_back", fetch_req_rdy, 1);
    tick();
    fetch_req_vld = 1'b0;
    settle();
    check("t3_mreq_vld", mem_req_vld, 1);
    check("t3_mreq_tag", mem_req_tag, 1);
    check("t3_mreq_addr", mem_req_addr, 32'h5000);
    rsps(4, '{0, 2, 3, 1}, '{8, 10, 11, 12});
    settle();
    check("t3_idle", busy, 0);

    // ROB stalled: FIFO fills, nothing lost
    icache_ack_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h40 * (i + 1), i, i);
    end
    for (int k = 0; k < 4; k++) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_tag  = TW'(k);
      mem_rsp_data = dat(k, k);
      tick();
    end
    mem_rsp_vld = 1'b0;
    settle();
    check("t4_full_rdy", fetch_req_rdy, 0);
    check("t4_busy", busy, 1);
    check("t4_head_vld", icache_ack_vld, 1);
    check("t4_head_id", icache_ack_entry_id, 0);
    check("t4_head_pld", icache_ack_pld, dat(0, 0));
    icache_ack_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      settle();
      check("t4_ack_vld", icache_ack_vld, 1);
      check("t4_ack_id", icache_ack_entry_id, k);
      check("t4_ack_pld", icache_ack_pld, dat(k, k));
    end
    tick();
    settle();
    check("t4_drained", icache_ack_vld, 0);
    check("t4_rdy_back", fetch_req_rdy, 1);

    // memory backpressure holds the request stable
    mem_req_rdy = 1'b0;
    send(32'h2000, 4, 0);
    fetch_req_vld      = 1'b1;
    fetch_req_pc       = 32'h3000;
    fetch_req_entry_id = 4'd5;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t5_hold_vld", mem_req_vld, 1);
      check("t5_hold_addr", mem_req_addr, 32'h2000);
      check("t5_hold_tag", mem_req_tag, 0);
      check("t5_hold_rdy", fetch_req_rdy, 0);
      tick();
    end
    mem_req_rdy = 1'b1;
    settle();
    check("t5_rel_rdy", fetch_req_rdy, 1);
    check("t5_rel_addr", mem_req_addr, 32'h2000);
    tick();
    fetch_req_vld = 1'b0;
    settle();
    check("t5_next_addr", mem_req_addr, 32'h3000);
    check("t5_next_tag", mem_req_tag, 1);
    tick();
    rsps(2, '{0, 1, 0, 0}, '{4, 5, 0, 0});
    settle();
    check("t5_idle", busy, 0);

    // reset with requests in flight; late rsp is dropped
    send(32'h6000, 5, 0);
    send(32'h6100, 6, 1);
    rst_n = 1'b0;
    #1;
    check("t6_mreq_vld", mem_req_vld, 0);
    check("t6_mreq_addr", mem_req_addr, 0);
    check("t6_mreq_tag", mem_req_tag, 0);
    check("t6_ack_vld", icache_ack_vld, 0);
    check("t6_ack_id", icache_ack_entry_id, 0);
    check("t6_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = 2'd0;
    mem_rsp_data = dat(5, 0);
    tick();
    mem_rsp_vld = 1'b0;
    settle();
    check("t6_late_ack", icache_ack_vld, 0);
    check("t6_late_busy", busy, 0);
    send(32'h7000, 7, 0);
    rsps(1, '{0, 0, 0, 0}, '{7, 0, 0, 0});
    settle();
    check("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
